// File: rtl/cadr_qreg_step.sv
// Q register plus multiply/divide step sequencer.
// Sits after the 74S181 ALU slice chain: captures F into Q, shifts Q under microcode
// control (qctl_i) or autonomously for Steps cycles once a sequence is started.
// Optional feature macro: QSTEP_ABORT_EN adds abort_i to cancel a running sequence.
module cadr_qreg_step #(
    parameter int unsigned Width = 32,
    parameter int unsigned Steps = 32,
    parameter int unsigned CntW  = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] alu_f_i,
    input  logic [1:0]       qctl_i,
    input  logic             start_i,
    input  logic             op_div_i,
`ifdef QSTEP_ABORT_EN
    input  logic             abort_i,
`endif
    output logic [Width-1:0] q_o,
    output logic             q_lsb_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CntW-1:0]  step_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CntW-1:0] StepsInit = CntW'(Steps);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    state_e           state_q, state_d;
    logic [Width-1:0] q_q, q_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             mode_q, mode_d;  // 1: divide (shift left), 0: multiply (shift right)
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort;

    logic [Width-1:0] q_shl;
    logic [Width-1:0] q_shr;

`ifdef QSTEP_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Divide step enters the quotient bit as the inverted ALU sign; multiply step feeds F0 in at msb.
    assign q_shl = {q_q[Width-2:0], ~alu_f_i[Width-1]};
    assign q_shr = {alu_f_i[0], q_q[Width-1:1]};

    // Next-state logic for Q, step counter, mode and sequencer state.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        unique case (state_q)
            StIdle, StDone: begin
                // Microcode keeps Q control whenever the sequencer is not running,
                // including the cycle that starts a sequence.
                unique case (qctl_i)
                    2'b00: q_d = q_q;
                    2'b01: q_d = q_shl;
                    2'b10: q_d = q_shr;
                    2'b11: q_d = alu_f_i;
                    default: q_d = q_q;
                endcase
                if (start_i) begin
                    state_d = StRun;
                    mode_d  = op_div_i;
                    cnt_d   = StepsInit;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    q_d = mode_q ? q_shl : q_shr;
                    if (cnt_q == CntOne) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    // State and registered handshake outputs; reset discards any partial Q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q_o        = q_q;
    assign q_lsb_o    = q_q[0];
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign step_cnt_o = cnt_q;

endmodule
